// File: rtl/turbo_pkg.sv
// turbo_pkg: shared FSM states, half-iteration encoding and default widths for the turbo iteration controller
package turbo_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int ITER_W_DEF = 4;
    localparam logic SISO1 = 1'b0;
    localparam logic SISO2 = 1'b1;
    typedef enum logic [2:0] {IDLE, FEED, WAIT, CHECK, DONE} state_e;
endpackage

// File: rtl/turbo_addr_cnt.sv
// turbo_addr_cnt: loadable block address counter that returns to 0 after accepting the last address
module turbo_addr_cnt import turbo_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_p_i,
    input  logic              reset_p_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] last_val_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    assign last_o = addr_q == last_val_i;
    assign addr_o = addr_q;
    always_comb addr_d = clr_i ? '0 : !inc_i ? addr_q : last_o ? '0 : addr_q + ADDR_W'(1);
    always_ff @(posedge clk_p_i or posedge reset_p_i)
        if (reset_p_i) addr_q <= '0;
        else addr_q <= addr_d;
endmodule

// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: time-multiplexes one SISO between natural and interleaved half-iterations
// and counts full iterations until the limit, convergence or abort.
module turbo_iter_ctrl import turbo_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ITER_W = ITER_W_DEF
) (
    input  logic              clk_p_i,
    input  logic              reset_p_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] block_last_i,
    input  logic [ITER_W-1:0] max_iter_i,
    input  logic              siso_rdy_i,
    input  logic              siso_done_i,
    input  logic              converged_i,
    output logic              siso_start_o,
    output logic              siso_sel_o,
    output logic              addr_vld_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ITER_W-1:0] iter_cnt_o
);
    state_e            state_q, state_d;
    logic              half_q, half_d, sstart_q, sstart_d, clr, inc, last;
    logic [ITER_W-1:0] iter_q, iter_d, max_q, max_d;
    logic [ADDR_W-1:0] blast_q, blast_d;

    turbo_addr_cnt #(.ADDR_W(ADDR_W)) u_addr (
        .clk_p_i(clk_p_i), .reset_p_i(reset_p_i), .clr_i(clr), .inc_i(inc),
        .last_val_i(blast_q), .addr_o(addr_o), .last_o(last)
    );

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        iter_d   = iter_q;
        max_d    = max_q;
        blast_d  = blast_q;
        sstart_d = 1'b0;
        clr      = 1'b0;
        inc      = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                blast_d  = block_last_i;
                max_d    = max_iter_i == '0 ? ITER_W'(1) : max_iter_i;
                half_d   = SISO1;
                iter_d   = '0;
                clr      = 1'b1;
                sstart_d = 1'b1;
                state_d  = FEED;
            end
            FEED: begin
                inc     = siso_rdy_i;
                state_d = siso_rdy_i && last ? WAIT : FEED;
            end
            WAIT: if (siso_done_i) begin
                half_d   = ~half_q;
                sstart_d = half_q == SISO1;
                iter_d   = half_q == SISO1 || &iter_q ? iter_q : iter_q + ITER_W'(1);
                state_d  = half_q == SISO1 ? FEED : CHECK;
            end
            CHECK: begin
                sstart_d = !(converged_i || iter_q >= max_q);
                state_d  = sstart_d ? FEED : DONE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything; the iteration count is left visible.
        if (abort_i && state_q != IDLE) begin
            state_d  = IDLE;
            half_d   = SISO1;
            iter_d   = iter_q;
            sstart_d = 1'b0;
            clr      = 1'b1;
            inc      = 1'b0;
        end
    end

    always_ff @(posedge clk_p_i or posedge reset_p_i)
        if (reset_p_i) begin
            state_q  <= IDLE;
            half_q   <= SISO1;
            iter_q   <= '0;
            max_q    <= '0;
            blast_q  <= '0;
            sstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            iter_q   <= iter_d;
            max_q    <= max_d;
            blast_q  <= blast_d;
            sstart_q <= sstart_d;
        end

    assign siso_start_o = sstart_q;
    assign siso_sel_o   = half_q;
    assign addr_vld_o   = state_q == FEED;
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;
    assign iter_cnt_o   = iter_q;
endmodule

// File: doc/turbo_iter_ctrl.md
# turbo_iter_ctrl

Iteration controller for the turbo decoder's single shared `siso` soft-in/soft-out unit. It time-multiplexes that unit between the two constituent decoders: a natural-order half-iteration (SISO1), then an interleaved-order half-iteration (SISO2). For each half-iteration it issues one start pulse and a valid/ready stream of block addresses to the extrinsic/LLR memories, waits for the SISO's completion pulse, and counts full iterations. It terminates on the iteration limit, on early convergence or on abort, and reports completion and the number of iterations run.

## Interface
- `ADDR_W`, default 10: address width; maximum block length is 2^ADDR_W.
- `ITER_W`, default 4: iteration counter width.
- `clk_p_i` in 1: clock; all logic is rising-edge.
- `reset_p_i` in 1: reset, asynchronous and active-high.
- `start_i` in 1: begin decoding a block. Sampled only in IDLE.
- `abort_i` in 1: abandon decoding. Takes priority over every other input.
- `block_last_i` in ADDR_W: block length minus 1. Captured when start_i is accepted.
- `max_iter_i` in ITER_W: iteration limit. Captured when start_i is accepted; a value of 0 is treated as 1.
- `siso_rdy_i` in 1: SISO accepts the current address this cycle.
- `siso_done_i` in 1: one-cycle pulse from the SISO marking the end of a half-iteration.
- `converged_i` in 1: early-stop flag. Sampled only in CHECK.
- `siso_start_o` out 1: one-cycle pulse at the start of each half-iteration.
- `siso_sel_o` out 1: 0 = SISO1, natural order; 1 = SISO2, interleaved order.
- `addr_vld_o` out 1: addr_o is valid.
- `addr_o` out ADDR_W: linear address, 0..block_last. The interleaver downstream maps it when siso_sel_o=1.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse on normal termination.
- `iter_cnt_o` out ITER_W: number of completed full iterations. Holds its value after done_o until the next accepted start.

## Operation
- States: IDLE, FEED, WAIT, CHECK, DONE.
- A `half` register drives siso_sel_o directly.
- IDLE, start_i=1:
  - Capture block_last_i and max_iter_i.
  - Set half=0, iter_cnt=0, addr=0.
  - Go to FEED.
- FEED:
  - addr_vld_o=1.
  - siso_start_o=1 in the first FEED cycle only.
  - On siso_rdy_i=1, the current address is accepted and addr increments.
  - When addr==block_last is accepted, go to WAIT and reset addr to 0.
  - When siso_rdy_i=0, addr_o holds and the state does not change.
- WAIT:
  - addr_vld_o=0. Wait for siso_done_i.
  - half=0 on done: set half=1 and go to FEED.
  - half=1 on done: increment iter_cnt, set half=0 and go to CHECK.
- CHECK (one cycle):
  - If converged_i=1 or iter_cnt ≥ max(max_iter,1), go to DONE.
  - Otherwise go to FEED.
- DONE (one cycle): done_o=1, then go to IDLE.
- abort_i=1 in any non-IDLE state:
  - Go to IDLE on the next edge with half=0 and addr=0.
  - No done_o pulse is generated.
  - iter_cnt_o keeps its current value.
- siso_done_i outside WAIT is ignored.
- start_i outside IDLE is ignored.
- Arithmetic:
  - addr is unsigned ADDR_W and never wraps, because it stops at block_last.
  - iter_cnt saturates at 2^ITER_W−1.
- Reset values: state=IDLE; half=0; addr=0; iter_cnt=0; all outputs 0.

## Timing
- All outputs are registered or decoded from state and registers only; there is no combinational path from any input to any output.
- From start_i accepted at edge N:
  - busy_o, siso_start_o and addr_vld_o are high, with addr_o=0, after edge N.
- Streaming rate: one address per cycle while siso_rdy_i=1. A half-iteration of L=block_last+1 addresses with no stalls occupies FEED for exactly L cycles.
- Between the last accepted address of SISO1 and the first address of SISO2: the WAIT duration plus 1 cycle.
- CHECK adds 1 cycle per full iteration.
- From the second siso_done_i of the final iteration to done_o: 2 cycles (CHECK, then DONE).
- abort_i asserted at edge N gives busy_o=0 after edge N.
- reset_p_i asserted at any time forces the reset values immediately, without waiting for a clock edge.

## Structure
- Package `turbo_pkg` holds:
  - the state enum (IDLE/FEED/WAIT/CHECK/DONE);
  - the half encoding constants SISO1=1'b0 and SISO2=1'b1;
  - the default ADDR_W and ITER_W.
- One sub-module is natural: `turbo_addr_cnt`. It is a loadable address counter with an increment enable and a `last` flag (addr==block_last).
- The FSM and the iteration counter stay in the top level.

## Test plan
- L=4 (block_last=3), max_iter=2, siso_rdy_i held at 1, SISO done returned 3 cycles after the last address, converged_i=0:
  - addresses 0,1,2,3 are issued four times, with sel sequence 0,1,0,1;
  - siso_start_o pulses 4 times;
  - done_o pulses once, with iter_cnt_o=2.
- Same block, converged_i=1 at the first CHECK:
  - done_o after one iteration, iter_cnt_o=1;
  - only 2 siso_start_o pulses.
- L=8, siso_rdy_i toggling 1,0,1,0:
  - each address is held while rdy=0;
  - no address is skipped or duplicated;
  - FEED lasts 15 cycles.
- max_iter_i=0, L=1: exactly 1 iteration; addr_o=0 is issued twice (sel 0, then sel 1).
- abort_i during SISO2 FEED of iteration 1:
  - busy_o=0 on the next cycle, no done_o;
  - a new start_i is accepted 1 cycle later with addr_o=0 and sel=0.
- reset_p_i pulsed mid-WAIT:
  - all outputs are 0 immediately, without a clock edge;
  - a spurious siso_done_i afterwards causes no state change.
